spmv_core: RTL and testbench
============================

Name: spmv_core

Overview:
- CSR sparse-matrix × dense-vector engine: accumulates A[k]·x[col(k)] products into one FP16 accumulator per row.
- Upstream fetch logic presents one nonzero at a time: A value, matching vector value B, and its 1-based element number `count`.
- Row membership is decoded from a CSR row-pointer bus.
- The 16 row results are exposed as a packed register with a done flag.

Parameters:
- N_ROWS, 16: number of matrix rows / accumulators.
- IDX_W, 8: width of element index and each row pointer.
- DATA_W, 16: IEEE-754 half-precision word width (fixed at 16).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  asynchronous, active-low reset.
- i_start  input  1  level start request, sampled in IDLE.
- i_read_data_A  input  16  FP16 matrix nonzero value for the current element.
- i_read_data_B  input  16  FP16 vector operand for the current element.
- count  input  IDX_W  1-based element number of current A/B pair; 0 = no element.
- row_ptr  input  (N_ROWS+1)*IDX_W  CSR pointers; ptr[r] = bits [IDX_W*r+IDX_W-1 : IDX_W*r]; ptr[N_ROWS] = nnz.
- o_done  output  1  high while results are final.
- o_register  output  N_ROWS*16  row r result at bits [16r+15:16r].

Behaviour:
- Reset (async, i_rstn=0):
  - state=IDLE, o_done=0, all accumulators=0 (o_register=0), internal latches=0.
  - Reset mid-operation aborts immediately.
- FSM states: IDLE, FETCH, MUL, ACC, WB, DONE.
- IDLE, on edge with i_start=1:
  - clear all accumulators;
  - latch A, B and count in the same edge (acts as first FETCH);
  - go to MUL.
- FETCH: latch A, B, count; go to MUL.
- MUL: product register = fp16_mul(A_lat, B_lat).
- ACC:
  - element index k = count_lat − 1;
  - target row = unique r with ptr[r] ≤ k < ptr[r+1] (empty rows never match);
  - sum = fp16_add(acc[row], product).
- WB:
  - write sum to acc[row] if the element is valid;
  - valid means count_lat ≠ 0, count_lat ≤ nnz, and a row matched;
  - invalid elements are dropped with no write;
  - if count_lat ≥ nnz go to DONE, else go to FETCH.
- Throughput and latency:
  - exactly one element every 4 cycles;
  - upstream holds A/B/count stable across each FETCH edge and advances every 4 cycles.
- DONE:
  - o_done=1, accumulators frozen;
  - if i_start=0, return to IDLE with o_done=0 and results retained until the next start clears them;
  - i_start held high keeps DONE.
- nnz=0 (ptr[N_ROWS]=0): first WB goes straight to DONE; all results 0.
- o_register is driven directly from accumulators, so partial sums are visible during operation.
- FP16 arithmetic:
  - IEEE binary16, round-to-nearest-even;
  - subnormal inputs and results flush to signed zero;
  - overflow → ±Inf; any NaN input or Inf·0 or Inf−Inf → 0x7E00;
  - multiply then add, each rounded (non-fused);
  - exact products and sums must be bit-exact.

Decomposition:
- Shared package holds:
  - N_ROWS, IDX_W, FP16 field widths (sign 1, exp 5, frac 10), bias 15;
  - constants FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00;
  - FSM state enum.
- One natural sub-module, fp16_arith, with combinational fp16 multiply and fp16 add functions/ports, instantiated once.
- Row decode is a comparator array in the core.

Test Plan:
- Reset: hold i_rstn=0 30 ns with i_start=1 → o_done=0, o_register=0; assert reset mid-run → outputs return to 0 asynchronously.
- Full CSR run, 10 ns clock:
  - row_ptr = 136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;
  - count 1..10, one per 4 cycles;
  - element 2 uses A=0x4200 (3), B=0x4700 (7); all others A=0x4C00 (16), B=0x4000 (2);
  - expected o_register: row1=0x5000, row2=0x4D40, row4=0x5000, row5=0x5000, row8=0x5600, row12=0x5400, row15=0x5000, all other rows 0x0000;
  - o_done rises 4 cycles after the 10th element is latched.
- Restart: drop i_start in DONE, reassert with a single-element matrix (ptr[1..16]=1, A=B=0x3C00) → row0=0x3C00, all others 0 (accumulators cleared).
- Invalid element: count=0 presented before valid data, or count > nnz → no accumulator change.
- Special values: A=0x7C00, B=0 → NaN 0x7E00 in target row; A=0x7BFF, B=0x4000 → 0x7C00; A=0x0001 (subnormal) → product 0.
- nnz=0 (all row_ptr bytes 0) → DONE after one element slot, o_register all zero.

Source files
------------

// File: rtl/spmv_core_pkg.sv
// Shared constants, FSM state encoding and FP16 packing helpers for the
// CSR sparse-matrix x dense-vector engine.
package spmv_core_pkg;

  localparam int N_ROWS = 16;
  localparam int IDX_W  = 8;
  localparam int DATA_W = 16;
  localparam int ROW_W  = $clog2(N_ROWS);

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  localparam logic [DATA_W-1:0] FP16_QNAN    = 16'h7E00;
  localparam logic [DATA_W-1:0] FP16_POS_INF = 16'h7C00;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_MUL   = 3'd2;
  localparam state_t S_ACC   = 3'd3;
  localparam state_t S_WB    = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Round-to-nearest-even and pack. n holds a normalised mantissa with the
  // hidden bit at [13], fraction at [12:3], guard at [2] and sticky at [1:0].
  // Results below the normal range flush to signed zero, above go to Inf.
  function automatic logic [DATA_W-1:0] fp16_round_pack(input logic s,
                                                        input logic signed [7:0] e,
                                                        input logic [13:0] n);
    logic              up;
    logic [11:0]       m;
    logic signed [7:0] ee;
    up = n[2] & (n[1] | n[0] | n[3]);
    m  = {1'b0, n[13:3]} + {11'd0, up};
    ee = m[11] ? e + 8'sd1 : e;
    if (ee >= 8'sd31)     return {s, FP16_POS_INF[14:0]};
    else if (ee <= 8'sd0) return {s, 15'd0};
    else                  return {s, ee[4:0], m[9:0]};
  endfunction

  // Leading-zero count used to renormalise after cancellation.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] c;
    logic       found;
    c     = 4'd0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      c = c + 4'd1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/spmv_core_arith.sv
// Combinational FP16 multiplier and adder (flush-to-zero, RNE, non-fused).
module fp16_arith
  import spmv_core_pkg::*;
(
  input  logic [DATA_W-1:0] mul_a,
  input  logic [DATA_W-1:0] mul_b,
  output logic [DATA_W-1:0] mul_y,
  input  logic [DATA_W-1:0] add_a,
  input  logic [DATA_W-1:0] add_b,
  output logic [DATA_W-1:0] add_y
);

  logic [EXP_W-1:0]  ma_e, mb_e;
  logic              ma_nan, mb_nan, ma_inf, mb_inf, ma_zero, mb_zero, mul_s;
  logic [21:0]       mul_p;
  logic [13:0]       mul_n;
  logic signed [7:0] mul_e;

  // Multiply: 11x11 mantissa product, one-bit normalise, then round.
  always_comb begin
    ma_e    = mul_a[14:10];
    mb_e    = mul_b[14:10];
    ma_nan  = (&ma_e) && (|mul_a[9:0]);
    mb_nan  = (&mb_e) && (|mul_b[9:0]);
    ma_inf  = (&ma_e) && !(|mul_a[9:0]);
    mb_inf  = (&mb_e) && !(|mul_b[9:0]);
    ma_zero = (ma_e == '0);
    mb_zero = (mb_e == '0);
    mul_s   = mul_a[15] ^ mul_b[15];
    mul_p   = {11'd0, 1'b1, mul_a[9:0]} * {11'd0, 1'b1, mul_b[9:0]};
    mul_n   = mul_p[21] ? {mul_p[21:9], |mul_p[8:0]} : {mul_p[20:8], |mul_p[7:0]};
    mul_e   = $signed({3'b000, ma_e}) + $signed({3'b000, mb_e}) - $signed(8'(BIAS))
              + (mul_p[21] ? 8'sd1 : 8'sd0);
    if (ma_nan || mb_nan || (ma_inf && mb_zero) || (mb_inf && ma_zero))
      mul_y = FP16_QNAN;
    else if (ma_inf || mb_inf)
      mul_y = {mul_s, FP16_POS_INF[14:0]};
    else if (ma_zero || mb_zero)
      mul_y = {mul_s, 15'd0};
    else
      mul_y = fp16_round_pack(mul_s, mul_e, mul_n);
  end

  logic [DATA_W-1:0] big, sml;
  logic [EXP_W-1:0]  aa_e, ab_e, d;
  logic              aa_nan, ab_nan, aa_inf, ab_inf, aa_zero, ab_zero, eff_sub;
  logic [13:0]       big_ext, sml_ext, sml_sh, sml_mask, sml_al, dif, add_n;
  logic [14:0]       sum15;
  logic [3:0]        lz;
  logic signed [7:0] add_e;

  // Add: order by magnitude, align with guard/sticky, add or subtract, renormalise.
  always_comb begin
    aa_e     = add_a[14:10];
    ab_e     = add_b[14:10];
    aa_nan   = (&aa_e) && (|add_a[9:0]);
    ab_nan   = (&ab_e) && (|add_b[9:0]);
    aa_inf   = (&aa_e) && !(|add_a[9:0]);
    ab_inf   = (&ab_e) && !(|add_b[9:0]);
    aa_zero  = (aa_e == '0);
    ab_zero  = (ab_e == '0);
    eff_sub  = add_a[15] ^ add_b[15];
    big      = (add_b[14:0] > add_a[14:0]) ? add_b : add_a;
    sml      = (add_b[14:0] > add_a[14:0]) ? add_a : add_b;
    d        = big[14:10] - sml[14:10];
    big_ext  = {1'b1, big[9:0], 3'b000};
    sml_ext  = {1'b1, sml[9:0], 3'b000};
    sml_sh   = '0;
    sml_mask = '0;
    if (d >= 5'd14) begin
      sml_al = 14'd1;
    end else begin
      sml_sh   = sml_ext >> d;
      sml_mask = (14'd1 << d) - 14'd1;
      sml_al   = {sml_sh[13:1], sml_sh[0] | (|(sml_ext & sml_mask))};
    end
    sum15 = {1'b0, big_ext} + {1'b0, sml_al};
    dif   = big_ext - sml_al;
    lz    = lzc14(dif);
    if (!eff_sub) begin
      if (sum15[14]) begin
        add_n = {sum15[14:2], |sum15[1:0]};
        add_e = $signed({3'b000, big[14:10]}) + 8'sd1;
      end else begin
        add_n = sum15[13:0];
        add_e = $signed({3'b000, big[14:10]});
      end
    end else begin
      add_n = dif << lz;
      add_e = $signed({3'b000, big[14:10]}) - $signed({4'b0000, lz});
    end
    if (aa_nan || ab_nan || (aa_inf && ab_inf && eff_sub))
      add_y = FP16_QNAN;
    else if (aa_inf)
      add_y = add_a;
    else if (ab_inf)
      add_y = add_b;
    else if (aa_zero && ab_zero)
      add_y = {add_a[15] & add_b[15], 15'd0};
    else if (aa_zero)
      add_y = add_b;
    else if (ab_zero)
      add_y = add_a;
    else if (eff_sub && dif == '0)
      add_y = '0;
    else
      add_y = fp16_round_pack(big[15], add_e, add_n);
  end

endmodule

// File: rtl/spmv_core.sv
// CSR SpMV engine: one nonzero per 4 cycles (FETCH/MUL/ACC/WB), one FP16
// accumulator per row, row picked by comparing the element index to row_ptr.
module spmv_core
  import spmv_core_pkg::*;
(
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_start,
  input  logic [DATA_W-1:0]            i_read_data_A,
  input  logic [DATA_W-1:0]            i_read_data_B,
  input  logic [IDX_W-1:0]             count,
  input  logic [(N_ROWS+1)*IDX_W-1:0]  row_ptr,
  output logic                         o_done,
  output logic [N_ROWS*DATA_W-1:0]     o_register
);

  state_t            state;
  logic [DATA_W-1:0] a_lat, b_lat, prod, sum;
  logic [IDX_W-1:0]  cnt_lat, elem_k, nnz;
  logic [ROW_W-1:0]  row_comb, row_lat;
  logic              row_any, elem_ok, wr_en;
  logic [DATA_W-1:0] mul_y, add_y;
  logic [DATA_W-1:0] acc [N_ROWS];
  logic [IDX_W-1:0]  ptr [N_ROWS+1];
  logic [N_ROWS-1:0] row_hit;

  assign elem_k  = cnt_lat - IDX_W'(1);
  assign nnz     = ptr[N_ROWS];
  assign elem_ok = (cnt_lat != '0) && (cnt_lat <= nnz) && row_any;
  assign o_done  = (state == S_DONE);

  for (genvar gi = 0; gi <= N_ROWS; gi++) begin : g_ptr
    assign ptr[gi] = row_ptr[IDX_W*gi +: IDX_W];
  end

  // Empty rows (ptr[r] == ptr[r+1]) can never satisfy both bounds.
  for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_hit
    assign row_hit[gi] = (ptr[gi] <= elem_k) && (elem_k < ptr[gi+1]);
    assign o_register[DATA_W*gi +: DATA_W] = acc[gi];
  end

  // Encode the (at most one) matching row.
  always_comb begin
    row_comb = '0;
    row_any  = 1'b0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (row_hit[r]) begin
        row_comb = ROW_W'(r);
        row_any  = 1'b1;
      end
    end
  end

  fp16_arith u_arith (
    .mul_a (a_lat),
    .mul_b (b_lat),
    .mul_y (mul_y),
    .add_a (acc[row_comb]),
    .add_b (prod),
    .add_y (add_y)
  );

  // Sequencer and pipeline latches; the start edge in IDLE doubles as the first FETCH.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= S_IDLE;
      a_lat   <= '0;
      b_lat   <= '0;
      cnt_lat <= '0;
      prod    <= '0;
      sum     <= '0;
      row_lat <= '0;
      wr_en   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FETCH: begin
          if (state == S_FETCH || i_start) begin
            a_lat   <= i_read_data_A;
            b_lat   <= i_read_data_B;
            cnt_lat <= count;
            state   <= S_MUL;
          end
        end
        S_MUL: begin
          prod  <= mul_y;
          state <= S_ACC;
        end
        S_ACC: begin
          sum     <= add_y;
          row_lat <= row_comb;
          wr_en   <= elem_ok;
          state   <= S_WB;
        end
        S_WB:    state <= (cnt_lat >= nnz) ? S_DONE : S_FETCH;
        S_DONE:  if (!i_start) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Accumulators: cleared on start, written back only for valid elements.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int r = 0; r < N_ROWS; r++) acc[r] <= '0;
    end else if (state == S_IDLE && i_start) begin
      for (int r = 0; r < N_ROWS; r++) acc[r] <= '0;
    end else if (state == S_WB && wr_en) begin
      acc[row_lat] <= sum;
    end
  end

endmodule

// File: tb/tb_spmv_core.sv
// Self-checking bench for spmv_core: directed CSR runs plus random matrices
// checked against a real-arithmetic FP16 reference model.
module tb_spmv_core;
  import spmv_core_pkg::*;

  logic         clk = 1'b0;
  logic         rstn, start;
  logic [15:0]  a, b;
  logic [7:0]   cnt;
  logic [135:0] row_ptr;
  logic         done;
  logic [255:0] oreg;

  int tests = 0;
  int fails = 0;

  logic [15:0] qa[$], qb[$];
  logic [7:0]  qc[$];
  logic [15:0] exp_acc [16];

  always #5 clk = ~clk;

  spmv_core dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start),
    .i_read_data_A(a), .i_read_data_B(b), .count(cnt),
    .row_ptr(row_ptr), .o_done(done), .o_register(oreg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real f2r(input logic [15:0] h);
    real v;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2f(input real x);
    logic s;
    real  m, fr, rem;
    int   e, q;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    fr  = (m - 1.0) * 1024.0;
    q   = $rtoi($floor(fr));
    rem = fr - $floor(fr);
    if (rem > 0.5 || (rem == 0.5 && (q % 2) == 1)) q++;
    if (q == 1024) begin q = 0; e++; end
    if (e < -14) return {s, 15'd0};
    if (e > 15)  return {s, 15'h7C00};
    return {s, 5'(e + 15), 10'(q)};
  endfunction

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 0);
  endfunction
  function automatic bit is_inf(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] == 0);
  endfunction
  function automatic bit is_zero(input logic [15:0] h);
    return h[14:10] == 5'd0;
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] x, input logic [15:0] y);
    logic s;
    s = x[15] ^ y[15];
    if (is_nan(x) || is_nan(y)) return 16'h7E00;
    if ((is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x))) return 16'h7E00;
    if (is_inf(x) || is_inf(y)) return {s, 15'h7C00};
    if (is_zero(x) || is_zero(y)) return {s, 15'd0};
    return r2f(f2r(x) * f2r(y));
  endfunction

  function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
    real r;
    if (is_nan(x) || is_nan(y)) return 16'h7E00;
    if (is_inf(x) && is_inf(y) && (x[15] != y[15])) return 16'h7E00;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    if (is_zero(x) && is_zero(y)) return {x[15] & y[15], 15'd0};
    r = f2r(x) + f2r(y);
    if (r == 0.0) return 16'h0000;
    return r2f(r);
  endfunction

  // Expected row results for the queued elements under the given pointers.
  task automatic model(input logic [135:0] p);
    int nnz, k;
    for (int r = 0; r < 16; r++) exp_acc[r] = 16'h0000;
    nnz = int'(p[128 +: 8]);
    for (int i = 0; i < qa.size(); i++) begin
      if (qc[i] != 0 && int'(qc[i]) <= nnz) begin
        k = int'(qc[i]) - 1;
        for (int r = 0; r < 16; r++)
          if (int'(p[8*r +: 8]) <= k && k < int'(p[8*(r+1) +: 8]))
            exp_acc[r] = m_add(exp_acc[r], m_mul(qa[i], qb[i]));
      end
    end
  endtask

  task automatic push(input logic [15:0] av, input logic [15:0] bv, input logic [7:0] cv);
    qa.push_back(av); qb.push_back(bv); qc.push_back(cv);
  endtask

  task automatic clearq();
    qa.delete(); qb.delete(); qc.delete();
  endtask

  // Drive one complete run (one element every 4 cycles) and compare every row.
  task automatic run(input logic [135:0] p, input string tag);
    row_ptr = p;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < qa.size(); i++) begin
      a = qa[i]; b = qb[i]; cnt = qc[i]; start = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      if (i == 0 && qa.size() > 1) check($sformatf("%s done_low", tag), done, 1'b0);
    end
    check($sformatf("%s done", tag), done, 1'b1);
    model(p);
    for (int r = 0; r < 16; r++)
      check($sformatf("%s row%0d", tag, r), oreg[16*r +: 16], exp_acc[r]);
    $display("[TB] run %s: %0d elements, nnz=%0d", tag, qa.size(), p[128 +: 8]);
  endtask

  logic [135:0] full_ptr, p;
  int           nnz_r, cuts[$];

  initial begin
    rstn = 1'b0; start = 1'b1; a = 16'h4C00; b = 16'h4000; cnt = 8'd1;
    full_ptr = 136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;
    row_ptr  = full_ptr;
    #30;
    check("reset done", done, 1'b0);
    check("reset oreg", oreg, 256'd0);
    @(negedge clk); rstn = 1'b1; start = 1'b0;

    // Full directed CSR matrix
    clearq();
    for (int c = 1; c <= 10; c++) begin
      if (c == 2) push(16'h4200, 16'h4700, 8'(c));
      else        push(16'h4C00, 16'h4000, 8'(c));
    end
    run(full_ptr, "full");
    check("full row2 const", oreg[16*2 +: 16], 16'h4D40);
    check("full row8 const", oreg[16*8 +: 16], 16'h5600);
    check("full row12 const", oreg[16*12 +: 16], 16'h5400);

    // Drop start: back to IDLE with results retained
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("idle done", done, 1'b0);
    check("idle retain row8", oreg[16*8 +: 16], 16'h5600);

    // Restart with a single-element matrix: previous results must be cleared
    p = '0;
    for (int r = 1; r <= 16; r++) p[8*r +: 8] = 8'd1;
    clearq();
    push(16'h3C00, 16'h3C00, 8'd1);
    run(p, "restart");
    check("restart row0 const", oreg[15:0], 16'h3C00);

    // Asynchronous reset in the middle of a run
    row_ptr = full_ptr;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'h4C00; b = 16'h4000; cnt = 8'd1; start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("partial row1", oreg[16*1 +: 16], 16'h5000);
    #2 rstn = 1'b0;
    #1;
    check("midreset oreg", oreg, 256'd0);
    check("midreset done", done, 1'b0);
    @(negedge clk); rstn = 1'b1; start = 1'b0;

    // Invalid elements: count=0 first, then count > nnz ends the run
    p = '0;
    p[8 +: 8] = 8'd1;
    for (int r = 2; r <= 16; r++) p[8*r +: 8] = 8'd2;
    clearq();
    push(16'h4C00, 16'h4000, 8'd0);
    push(16'h3C00, 16'h4000, 8'd1);
    push(16'h4C00, 16'h4C00, 8'd3);
    run(p, "invalid");
    check("invalid row0 const", oreg[15:0], 16'h4000);

    // Special values: Inf*0, overflow, subnormal input
    p = '0;
    p[8 +: 8] = 8'd1; p[16 +: 8] = 8'd2;
    for (int r = 3; r <= 16; r++) p[8*r +: 8] = 8'd3;
    clearq();
    push(16'h7C00, 16'h0000, 8'd1);
    push(16'h7BFF, 16'h4000, 8'd2);
    push(16'h0001, 16'h4000, 8'd3);
    run(p, "special");
    check("special nan const", oreg[15:0], 16'h7E00);
    check("special inf const", oreg[31:16], 16'h7C00);
    check("special sub const", oreg[47:32], 16'h0000);

    // Empty matrix: DONE after one element slot
    clearq();
    push(16'h4C00, 16'h4000, 8'd1);
    run(136'd0, "nnz0");
    check("nnz0 oreg const", oreg, 256'd0);

    // Random CSR matrices
    for (int t = 0; t < 6; t++) begin
      nnz_r = $urandom_range(1, 24);
      cuts.delete();
      for (int r = 1; r < 16; r++) cuts.push_back($urandom_range(0, nnz_r));
      cuts.sort();
      p = '0;
      for (int r = 1; r < 16; r++) p[8*r +: 8] = 8'(cuts[r-1]);
      p[128 +: 8] = 8'(nnz_r);
      clearq();
      for (int c = 1; c <= nnz_r; c++) begin
        if ($urandom_range(0, 4) == 0) push(16'h5000, 16'h5000, 8'd0);
        push({1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))},
             {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)), 10'($urandom_range(0, 1023))},
             8'(c));
      end
      run(p, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
